// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive pair: FSM state
// encodings, default bit timing and line levels.
package serial_pkg;

  // Default bit period in CLK cycles; the receiver uses the same constant.
  localparam int SERIAL_CLKS_PER_BIT = 16;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  // Frame FSM states (PARITY only reachable when parity is built in).
  typedef enum logic [2:0] {
    SER_IDLE   = 3'd0,
    SER_START  = 3'd1,
    SER_DATA   = 3'd2,
    SER_PARITY = 3'd3,
    SER_STOP   = 3'd4
  } serial_state_e;

  // Even parity bit: set when the byte has an odd number of ones.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/serial_tx_buffered_if.sv
// Producer-side bus of the buffered serial transmitter.
// master = byte producer, slave = transmitter.
interface serial_tx_buffered_if;
  logic [7:0] IN_DATA;
  logic       IN_WRITE;
  logic       OUT_FULL;
  logic       OUT_EMPTY;
  logic       OUT_BUSY;
  logic       OUT_OVERFLOW;
  logic       OUT_SERIAL_TX;

  modport master (
    output IN_DATA, IN_WRITE,
    input  OUT_FULL, OUT_EMPTY, OUT_BUSY, OUT_OVERFLOW, OUT_SERIAL_TX
  );

  modport slave (
    input  IN_DATA, IN_WRITE,
    output OUT_FULL, OUT_EMPTY, OUT_BUSY, OUT_OVERFLOW, OUT_SERIAL_TX
  );
endinterface

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with show-ahead read data. Pushes while full and
// pops while empty are ignored. Shared by the transmit and receive sides.
module sync_byte_fifo #(
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next pointers/count; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/serial_tx_buffered.sv
// Buffered asynchronous serial transmitter: bytes are queued in a FIFO and
// sent as start / 8 data (LSB first) / stop frames, back to back when the
// FIFO stays non-empty.
// Optional: define SERIAL_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frame).
module serial_tx_buffered import serial_pkg::*; #(
  parameter int CLKS_PER_BIT = SERIAL_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input logic                 CLK,
  input logic                 RESET,
  serial_tx_buffered_if.slave bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] ST_IDLE   = SER_IDLE;
  localparam logic [2:0] ST_START  = SER_START;
  localparam logic [2:0] ST_DATA   = SER_DATA;
  localparam logic [2:0] ST_STOP   = SER_STOP;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = SER_PARITY;
`endif

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic             pop;
  logic [7:0]       fifo_head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             have_data;
  logic             baud_last;

  sync_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .push    (bus.IN_WRITE),
    .pop     (pop),
    .wr_data (bus.IN_DATA),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign have_data = (fifo_count != '0);
  assign baud_last = (baud_q == BAUD_LAST);

  assign bus.OUT_FULL      = fifo_full;
  assign bus.OUT_EMPTY     = fifo_empty;
  assign bus.OUT_BUSY      = (state_q != ST_IDLE);
  assign bus.OUT_OVERFLOW  = ovf_q;
  assign bus.OUT_SERIAL_TX = tx_q;

  // Frame sequencer; tx_d is the line level for the cycle after the edge,
  // so the output flop changes together with the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = IDLE_LEVEL;
        if (have_data) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          baud_d  = '0;
          state_d = ST_START;
          tx_d    = START_LEVEL;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = even_parity(fifo_head);
`endif
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = STOP_LEVEL;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_STOP;
          tx_d    = STOP_LEVEL;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data waits.
          if (have_data) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = ST_START;
            tx_d    = START_LEVEL;
`ifdef SERIAL_TX_PARITY_EN
            parity_d = even_parity(fifo_head);
`endif
          end else begin
            state_d = ST_IDLE;
            tx_d    = IDLE_LEVEL;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        tx_d    = IDLE_LEVEL;
      end
    endcase
  end

  // Overflow is sticky: any write seen while full, even with a pop in flight.
  always_comb begin
    ovf_d = ovf_q | (bus.IN_WRITE & fifo_full);
  end

  // Sequencer, shift register and registered line output.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= IDLE_LEVEL;
      ovf_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx_buffered.sv
// Bench for serial_tx_buffered: hand-tabulated frames, multi-cycle corner
// sequences, and random writes against a frame-timeline reference model.
module tb_serial_tx_buffered;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  logic CLK = 1'b0;
  logic RESET;

  serial_tx_buffered_if bus();

  serial_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Accepted bytes wait in m_q. A frame occupies FRAME cycles after the
  // edge that pops it; m_rem counts the cycles still left after the current one.
  logic [7:0] m_q[$];
  int         m_rem;
  bit         m_act;
  logic [7:0] m_cur;
  bit         m_ovf;

  function automatic logic m_tx();
    int pos, b;
    if (!m_act) return 1'b1;
    pos = FRAME - 1 - m_rem;
    b   = pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
`ifdef SERIAL_TX_PARITY_EN
    if (b == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rem = 0;
    m_act = 0;
    m_cur = '0;
    m_ovf = 0;
  endtask

  task automatic model_edge(input bit wr, input logic [7:0] d);
    bit pop, acc;
    pop = (m_q.size() > 0) && (!m_act || m_rem == 0);
    acc = wr && (m_q.size() < DEPTH);
    if (wr && m_q.size() == DEPTH) m_ovf = 1;
    if (pop) begin
      m_cur = m_q.pop_front();
      m_act = 1;
      m_rem = FRAME - 1;
    end else if (m_act) begin
      if (m_rem == 0) m_act = 0;
      else m_rem--;
    end
    if (acc) m_q.push_back(d);
  endtask

  task automatic check_model(input string tag);
    logic [4:0] got, exp;
    got = {bus.OUT_SERIAL_TX, bus.OUT_BUSY, bus.OUT_FULL, bus.OUT_EMPTY, bus.OUT_OVERFLOW};
    exp = {m_tx(), m_act, (m_q.size() == DEPTH), (m_q.size() == 0), m_ovf};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t tx/busy/full/empty/ovf got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %b expected %b", name, $time, got, exp);
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input bit wr, input logic [7:0] d, input string tag);
    bus.IN_WRITE = wr;
    bus.IN_DATA  = d;
    @(posedge CLK);
    model_edge(wr, d);
    @(negedge CLK);
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    #2;
    RESET = 1'b1;
    bus.IN_WRITE = 1'b0;
    #1;
    check1({tag, "_tx"},    bus.OUT_SERIAL_TX, 1'b1);
    check1({tag, "_empty"}, bus.OUT_EMPTY,     1'b1);
    check1({tag, "_full"},  bus.OUT_FULL,      1'b0);
    check1({tag, "_busy"},  bus.OUT_BUSY,      1'b0);
    check1({tag, "_ovf"},   bus.OUT_OVERFLOW,  1'b0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((m_act || m_q.size() > 0) && guard < (DEPTH + 2) * FRAME) begin
      step(1'b0, 8'h00, tag);
      guard++;
    end
    n_tests++;
    if (m_act || m_q.size() > 0) begin
      n_fail++;
      $display("FAIL %s_timeout got busy after %0d cycles expected idle", tag, guard);
    end
  endtask

  // ---------------- table of hand-derived frames ----------------
  // frame = {stop, data[7:0], start}, bit 0 sent first; par = even parity.
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs[7];

  function automatic logic exp_bit(input vec_t v, input int i);
    if (i <= 8) return v.frame[i];
`ifdef SERIAL_TX_PARITY_EN
    if (i == 9) return v.par;
`endif
    return 1'b1;
  endfunction

  // Write one byte into an idle transmitter and check every cycle of its frame.
  task automatic send_and_check(input vec_t v);
    int bad;
    logic e;
    step(1'b1, v.data, "tbl_wr");
    check1("tbl_pre_start", bus.OUT_SERIAL_TX, 1'b1);
    for (int b = 0; b < FRAME_BITS; b++) begin
      e = exp_bit(v, b);
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        step(1'b0, 8'h00, "tbl_frame");
        if (b == 0 && c == 0) check1("tbl_busy_rise", bus.OUT_BUSY, 1'b1);
        if (bus.OUT_SERIAL_TX !== e) bad++;
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL tbl_bit data=%h bit=%0d got %0d wrong cycles expected level %b", v.data, b, bad, e);
      end
    end
    check1("tbl_busy_last", bus.OUT_BUSY, 1'b1);
    step(1'b0, 8'h00, "tbl_end");
    check1("tbl_busy_fall", bus.OUT_BUSY, 1'b0);
    check1("tbl_tx_idle",   bus.OUT_SERIAL_TX, 1'b1);
  endtask

  initial begin
    logic samples[$];
    logic [7:0] dec;
    int base, trans;
    logic prev;
    int p;

    vecs[0] = '{8'h55, 10'h2AA, 1'b0};
    vecs[1] = '{8'h07, 10'h20E, 1'b1};
    vecs[2] = '{8'h03, 10'h206, 1'b0};
    vecs[3] = '{8'hA5, 10'h34A, 1'b0};
    vecs[4] = '{8'h3C, 10'h278, 1'b0};
    vecs[5] = '{8'h80, 10'h300, 1'b1};
    vecs[6] = '{8'hFF, 10'h3FE, 1'b0};

    RESET = 1'b1;
    bus.IN_WRITE = 1'b0;
    bus.IN_DATA  = 8'h00;
    model_reset();
    do_reset("rst0");

    // Idle after reset: line stays high, no transitions.
    trans = 0;
    prev = bus.OUT_SERIAL_TX;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'h00, "idle");
      if (bus.OUT_SERIAL_TX !== prev) trans++;
      prev = bus.OUT_SERIAL_TX;
    end
    n_tests++;
    if (trans != 0) begin
      n_fail++;
      $display("FAIL idle_transitions got %0d expected 0", trans);
    end

    // Table-driven single frames.
    for (int i = 0; i < 7; i++) send_and_check(vecs[i]);

    // Three consecutive writes: contiguous frames, decoded back in order.
    samples.delete();
    step(1'b1, 8'h41, "b2b");
    samples.push_back(bus.OUT_SERIAL_TX);
    step(1'b1, 8'h42, "b2b");
    samples.push_back(bus.OUT_SERIAL_TX);
    step(1'b1, 8'h43, "b2b");
    samples.push_back(bus.OUT_SERIAL_TX);
    for (int i = 0; i < 3 * FRAME + 4; i++) begin
      step(1'b0, 8'h00, "b2b");
      samples.push_back(bus.OUT_SERIAL_TX);
    end
    for (int n = 0; n < 3; n++) begin
      base = 1 + n * FRAME;
      for (int b = 0; b < 8; b++) dec[b] = samples[base + (b + 1) * CPB + CPB / 2];
      n_tests++;
      if (dec !== 8'(8'h41 + n)) begin
        n_fail++;
        $display("FAIL b2b_byte%0d got %h expected %h", n, dec, 8'(8'h41 + n));
      end
      check1("b2b_start", samples[base + CPB / 2], 1'b0);
      check1("b2b_start_edge", samples[base], 1'b0);
      check1("b2b_stop", samples[base + FRAME - 1], 1'b1);
    end
    drain("b2b_drain");

    // Nine writes while idle are all accepted; the tenth overflows.
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h10 + i), "fill");
    check1("fill_full", bus.OUT_FULL, 1'b1);
    check1("fill_ovf0", bus.OUT_OVERFLOW, 1'b0);
    step(1'b1, 8'hEE, "ovf_wr");
    check1("ovf_full", bus.OUT_FULL, 1'b1);
    check1("ovf_set", bus.OUT_OVERFLOW, 1'b1);
    drain("ovf_drain");
    check1("ovf_sticky", bus.OUT_OVERFLOW, 1'b1);

    // Reset in the middle of the data bits of 0xA5, then send 0x3C cleanly.
    do_reset("rst_ovf");
    step(1'b1, 8'hA5, "mid_wr");
    for (int i = 0; i < CPB * 4 + 5; i++) step(1'b0, 8'h00, "mid_run");
    check1("mid_busy", bus.OUT_BUSY, 1'b1);
    do_reset("rst_mid");
    step(1'b0, 8'h00, "post_rst");
    send_and_check(vecs[4]);

    // Random write bursts at varying rates.
    for (int seg = 0; seg < 8; seg++) begin
      p = $urandom_range(1, 30);
      for (int i = 0; i < 500; i++)
        step($urandom_range(0, 99) < p, 8'($urandom), "rand");
    end
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
